// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester memory/GPIO port arbiter with lock and round-robin
// Option: define MEM_ARBITER_FIXED_PRIO_EN to make requester 0 win every tie.
module mem_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_Req0,
  input  logic        i_Req1,
  input  logic        i_Lock0,
  input  logic        i_Lock1,
  input  logic [31:0] i_A0,
  input  logic [31:0] i_A1,
  input  logic        i_WE0,
  input  logic        i_WE1,
  input  logic [31:0] i_D0,
  input  logic [31:0] i_D1,
  output logic        o_Ack0,
  output logic        o_Ack1,
  output logic [31:0] o_Q0,
  output logic [31:0] o_Q1,
  output logic [1:0]  o_Gnt,
  output logic [31:0] o_MemA,
  output logic        o_MemWE,
  output logic [31:0] o_MemD,
  input  logic [31:0] i_MemQ
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

  state_t         state_q, state_d;
  logic [1:0]     gnt_q, gnt_d;
  logic           last_q, last_d;   // owner of the current/last transaction, 1 = requester 1
  logic           we_q, we_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    d_q, d_d;
  logic [31:0]    q0_q, q0_d;
  logic [31:0]    q1_q, q1_d;
  logic           hold_q, hold_d;   // lock keeps the grant for the next IDLE
  logic           exh_q, exh_d;     // lock ran out; the other requester goes first
  logic [CW-1:0]  cnt_q, cnt_d;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
  logic           ptr_q, ptr_d;
`endif

  logic [1:0] req_v;
  logic       win;
  logic       via_hold;
  logic       lk;

  assign req_v = {i_Req1, i_Req0};

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    a_d      = a_q;
    d_d      = d_q;
    q0_d     = q0_q;
    q1_d     = q1_q;
    hold_d   = hold_q;
    exh_d    = exh_q;
    cnt_d    = cnt_q;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    win      = 1'b0;
    via_hold = 1'b0;
    lk       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_v) begin
          if (hold_q && req_v[last_q]) begin
            win      = last_q;
            via_hold = 1'b1;
          end else if (exh_q && req_v[~last_q]) begin
            win = ~last_q;
          end else if (&req_v) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ptr_q;
`endif
          end else begin
            win = i_Req1;
          end
          gnt_d   = win ? 2'b10 : 2'b01;
          last_d  = win;
          a_d     = win ? i_A1 : i_A0;
          d_d     = win ? i_D1 : i_D0;
          we_d    = win ? i_WE1 : i_WE0;
          cnt_d   = via_hold ? cnt_q + 1'b1 : '0;
          hold_d  = 1'b0;
          exh_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!we_q) begin
          if (last_q) q1_d = i_MemQ;
          else        q0_d = i_MemQ;
        end
        state_d = ACK;
      end
      ACK: begin
        lk     = last_q ? (i_Lock1 && i_Req1) : (i_Lock0 && i_Req0);
        hold_d = lk && (cnt_q < LOCK_MAX_C);
        exh_d  = lk && !(cnt_q < LOCK_MAX_C);
        if (!lk) cnt_d = '0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
        if (!hold_d) ptr_d = ~last_q;
`endif
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      q0_q    <= '0;
      q1_q    <= '0;
      hold_q  <= 1'b0;
      exh_q   <= 1'b0;
      cnt_q   <= '0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      a_q     <= a_d;
      d_q     <= d_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      hold_q  <= hold_d;
      exh_q   <= exh_d;
      cnt_q   <= cnt_d;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign o_Gnt   = gnt_q;
  assign o_Ack0  = (state_q == ACK) && !last_q;
  assign o_Ack1  = (state_q == ACK) && last_q;
  assign o_MemWE = (state_q == BUSY) && we_q;
  assign o_MemA  = a_q;
  assign o_MemD  = d_q;
  assign o_Q0    = q0_q;
  assign o_Q1    = q1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        i_Req0 = 1'b0, i_Req1 = 1'b0;
  logic        i_Lock0 = 1'b0, i_Lock1 = 1'b0;
  logic [31:0] i_A0 = '0, i_A1 = '0;
  logic        i_WE0 = 1'b0, i_WE1 = 1'b0;
  logic [31:0] i_D0 = '0, i_D1 = '0;
  logic        o_Ack0, o_Ack1;
  logic [31:0] o_Q0, o_Q1;
  logic [1:0]  o_Gnt;
  logic [31:0] o_MemA, o_MemD;
  logic        o_MemWE;
  logic [31:0] i_MemQ;

  int checks = 0;
  int errors = 0;

  // Memory model: read data is a fixed function of the address (5 -> 0xDEADBEEF).
  assign i_MemQ = o_MemA ^ 32'hDEADBEEA;

  always #5 Clk = ~Clk;

  mem_arbiter #(.LOCK_MAX(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .i_Req0(i_Req0), .i_Req1(i_Req1),
    .i_Lock0(i_Lock0), .i_Lock1(i_Lock1),
    .i_A0(i_A0), .i_A1(i_A1),
    .i_WE0(i_WE0), .i_WE1(i_WE1),
    .i_D0(i_D0), .i_D1(i_D1),
    .o_Ack0(o_Ack0), .o_Ack1(o_Ack1),
    .o_Q0(o_Q0), .o_Q1(o_Q1),
    .o_Gnt(o_Gnt),
    .o_MemA(o_MemA), .o_MemWE(o_MemWE), .o_MemD(o_MemD),
    .i_MemQ(i_MemQ)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, {30'd0, o_Gnt}, 32'd0);
    check({tag, "_ack"}, {30'd0, o_Ack1, o_Ack0}, 32'd0);
    check({tag, "_we"}, {31'd0, o_MemWE}, 32'd0);
  endtask

  initial begin
    logic [1:0] exp_g;
    logic       w;

    // Reset state
    step();
    step();
    check_idle_outputs("rst");
    check("rst_mema", o_MemA, 32'd0);
    check("rst_memd", o_MemD, 32'd0);
    check("rst_q0", o_Q0, 32'd0);
    check("rst_q1", o_Q1, 32'd0);
    Reset = 1'b1;
    step();
    check_idle_outputs("idle");

    // Single read by requester 0
    i_Req0 = 1'b1; i_A0 = 32'd5; i_WE0 = 1'b0;
    step();
    check("rd_busy_gnt", {30'd0, o_Gnt}, 32'd1);
    check("rd_busy_mema", o_MemA, 32'd5);
    check("rd_busy_we", {31'd0, o_MemWE}, 32'd0);
    check("rd_busy_ack", {30'd0, o_Ack1, o_Ack0}, 32'd0);
    step();
    check("rd_ack", {30'd0, o_Ack1, o_Ack0}, 32'd1);
    check("rd_q0", o_Q0, 32'hDEADBEEF);
    i_Req0 = 1'b0;
    step();
    check_idle_outputs("rd_done");
    check("rd_q0_hold", o_Q0, 32'hDEADBEEF);
    check("rd_mema_hold", o_MemA, 32'd5);

    // Single write by requester 1
    i_Req1 = 1'b1; i_A1 = 32'h20; i_D1 = 32'hFF; i_WE1 = 1'b1;
    step();
    check("wr_busy_we", {31'd0, o_MemWE}, 32'd1);
    check("wr_busy_mema", o_MemA, 32'h20);
    check("wr_busy_memd", o_MemD, 32'hFF);
    check("wr_busy_gnt", {30'd0, o_Gnt}, 32'd2);
    step();
    check("wr_ack_we", {31'd0, o_MemWE}, 32'd0);
    check("wr_ack", {30'd0, o_Ack1, o_Ack0}, 32'd2);
    check("wr_q1", o_Q1, 32'd0);
    i_Req1 = 1'b0; i_WE1 = 1'b0;
    step();
    check_idle_outputs("wr_done");

    // Contention: both requesters reading, 4 transactions
    i_A0 = 32'h100; i_A1 = 32'h200;
    i_Req0 = 1'b1; i_Req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = k[0];
`endif
      exp_g = w ? 2'b10 : 2'b01;
      step();
      check("ct_gnt", {30'd0, o_Gnt}, {30'd0, exp_g});
      step();
      check("ct_ack", {30'd0, o_Ack1, o_Ack0}, {30'd0, exp_g});
      if (w) check("ct_q1", o_Q1, 32'hDEADBCEA);
      else   check("ct_q0", o_Q0, 32'hDEADBFEA);
      if (k == 3) begin
        i_Req0 = 1'b0; i_Req1 = 1'b0;
      end
      step();
      check("ct_idle_ack", {30'd0, o_Ack1, o_Ack0}, 32'd0);
    end
    check_idle_outputs("ct_done");

    // Lock limit: 5 requester-0 transactions, then requester 1
    i_Lock0 = 1'b1; i_Req0 = 1'b1; i_Req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_g = (k < 5) ? 2'b01 : 2'b10;
      step();
      check("lk_gnt", {30'd0, o_Gnt}, {30'd0, exp_g});
      step();
      check("lk_ack", {30'd0, o_Ack1, o_Ack0}, {30'd0, exp_g});
      if (k == 5) begin
        i_Req0 = 1'b0; i_Req1 = 1'b0; i_Lock0 = 1'b0;
      end
      step();
    end
    check_idle_outputs("lk_done");

    // Reset while a write is in BUSY
    i_Req0 = 1'b1; i_WE0 = 1'b1; i_A0 = 32'h44; i_D0 = 32'h77;
    step();
    check("rb_busy_we", {31'd0, o_MemWE}, 32'd1);
    Reset = 1'b0;
    i_Req0 = 1'b0; i_WE0 = 1'b0;
    step();
    check_idle_outputs("rb_rst");
    check("rb_mema", o_MemA, 32'd0);
    check("rb_memd", o_MemD, 32'd0);
    check("rb_q0", o_Q0, 32'd0);
    check("rb_q1", o_Q1, 32'd0);
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_idle_outputs("rb_after");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 4: maximum consecutive locked transactions granted to one requester.
REQ-002 SHALL have port Clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1: synchronous active-low reset.
REQ-004 SHALL have ports i_Req0 / i_Req1, input, 1 each: transaction request, held until the matching ack.
REQ-005 SHALL have ports i_Lock0 / i_Lock1, input, 1 each: requester asks to keep the grant for its next transaction.
REQ-006 SHALL have ports i_A0 / i_A1, input, 32 each: requester word address.
REQ-007 SHALL have ports i_WE0 / i_WE1, input, 1 each: 1 = write, 0 = read.
REQ-008 SHALL have ports i_D0 / i_D1, input, 32 each: requester write data.
REQ-009 SHALL have ports o_Ack0 / o_Ack1, output, 1 each: one-cycle completion pulse.
REQ-010 SHALL have ports o_Q0 / o_Q1, output, 32 each: read data, valid while the matching ack is high and held until that requester's next read completes.
REQ-011 SHALL have port o_Gnt, output, 2: one-hot owner of the memory port; 00 when idle.
REQ-012 SHALL have ports o_MemA (32), o_MemWE (1) and o_MemD (32), outputs: shared memory/GPIO port address, write enable and write data.
REQ-013 SHALL have port i_MemQ, input, 32: combinational read data from the shared memory port.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BUSY, ACK.
REQ-015 IDLE: requests SHALL be sampled only in this state; with none pending, remain IDLE and hold o_Gnt = 00.
REQ-016 IDLE with at least one request: SHALL select a winner, latch its A/WE/D, set o_Gnt one-hot and go to BUSY on the next edge.
REQ-017 Winner selection SHALL follow REQ-030; a lone requester always wins.
REQ-018 BUSY: SHALL drive the latched values on o_MemA and o_MemD, assert o_MemWE = latched WE for exactly this one cycle, and go to ACK.
REQ-019 At the BUSY-to-ACK edge, a read SHALL capture i_MemQ into the winner's o_Q register; a write SHALL leave o_Q unchanged.
REQ-020 ACK: SHALL pulse the winner's o_Ack for one cycle, keep o_MemWE = 0 and return to IDLE.
REQ-021 Latency SHALL be 3 cycles: request seen in IDLE at edge N, ack high during cycle N+2, next request sampled at edge N+3.
REQ-022 Outside BUSY, o_MemWE SHALL be 0; o_MemA and o_MemD SHALL hold their last values.
REQ-023 Lock: if the winner has Lock and Req high during ACK and the lock count is below LOCK_MAX, the next IDLE SHALL grant the same requester and increment the count.
REQ-024 The lock count SHALL reset to 0 whenever the grant moves to the other requester or the winner's Lock is low.
REQ-025 When the lock count reaches LOCK_MAX and the other requester is pending, the grant SHALL pass to it.
REQ-026 A request dropped before its ack SHALL NOT abort the transaction in flight; no ack is issued for a request never sampled.
REQ-027 Simultaneous Req0 and Req1 with no valid lock SHALL be resolved by the priority pointer only.

Reset
REQ-028 While Reset = 0 at a rising Clk edge: state = IDLE; o_Gnt = 00; o_Ack0/1 = 0; o_MemWE = 0; o_MemA, o_MemD, o_Q0 and o_Q1 = 0; priority pointer = requester 0; lock count = 0.
REQ-029 Reset asserted in BUSY or ACK SHALL abandon the transaction: no ack is issued and no write occurs after the reset edge.

Configuration
REQ-030 Macro MEM_ARBITER_FIXED_PRIO_EN: when defined, requester 0 SHALL always win a tie, lock still applies and the pointer is unused; when undefined, round-robin SHALL apply, with the pointer moving to the non-winner after each ACK unless the lock retains the grant.

Verification
REQ-031 Single read: Req0 = 1, A0 = 5, WE0 = 0, memory returns 0xDEADBEEF -> o_MemA = 5 for one cycle, o_Ack0 pulses 2 cycles after sampling, o_Q0 = 0xDEADBEEF.
REQ-032 Single write: Req1 = 1, A1 = 0x20, D1 = 0x0000_00FF, WE1 = 1 -> o_MemWE high exactly one cycle with o_MemA = 0x20 and o_MemD = 0xFF, then o_Ack1; o_Q1 unchanged.
REQ-033 Contention, round-robin: Req0 and Req1 both held for 4 transactions -> grant order 0,1,0,1 and acks spaced 3 cycles apart; with MEM_ARBITER_FIXED_PRIO_EN defined -> order 0,0,0,0.
REQ-034 Lock limit: Lock0 = Req0 = 1 and Req1 = 1, LOCK_MAX = 4 -> 5 consecutive requester-0 transactions (initial grant plus 4 locked), then requester 1.
REQ-035 Reset mid-BUSY with a write pending: Reset = 0 at the BUSY edge -> no o_MemWE pulse after that edge, no ack, all outputs 0, state IDLE.
